// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address-map constants and the fetch FSM state encoding.
package cpu_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC   = 32'h0040_0004;
  localparam int          STEP      = 4;
  localparam int          CNT_W     = 32;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority selection and redirect-target alignment check.
module pc_next_mux
  import cpu_pkg::*;
#(
  parameter int              XLEN    = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] EXC_VEC = cpu_pkg::EXC_VEC,
  parameter int              STEP    = cpu_pkg::STEP
) (
  input  logic [XLEN-1:0] pc,
  input  logic            exc_req,
  input  logic            eret_req,
  input  logic [XLEN-1:0] epc_i,
  input  logic            redir_vld,
  input  logic [XLEN-1:0] redir_pc,
  input  logic            halt_i,
  input  logic            accept,
  output logic [XLEN-1:0] next_pc,
  output logic            flush,
  output logic            set_misalign,
  output logic            go_halt,
  output logic            count
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);

  logic aligned;

  assign aligned = ((redir_pc & ALIGN_MASK) == '0);

  // Traps and redirects win over holds; only a plain sequential step counts as a fetch.
  always_comb begin
    next_pc      = pc;
    flush        = 1'b0;
    set_misalign = 1'b0;
    go_halt      = 1'b0;
    count        = 1'b0;
    if (exc_req) begin
      next_pc = EXC_VEC;
      flush   = 1'b1;
    end else if (eret_req) begin
      next_pc = epc_i;
      flush   = 1'b1;
    end else if (redir_vld) begin
      flush = 1'b1;
      if (aligned) begin
        next_pc = redir_pc;
      end else begin
        next_pc      = EXC_VEC;
        set_misalign = 1'b1;
      end
    end else if (halt_i) begin
      go_halt = 1'b1;
    end else if (accept) begin
      next_pc = pc + XLEN'(STEP);
      count   = 1'b1;
    end
  end

endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage program-counter generator: BOOT/RUN/HALT FSM, PC and trap flag registers, fetch counter.
module pc_gen_unit
  import cpu_pkg::*;
#(
  parameter int               XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_VEC = cpu_pkg::RESET_VEC,
  parameter logic [XLEN-1:0]  EXC_VEC   = cpu_pkg::EXC_VEC,
  parameter int               STEP      = cpu_pkg::STEP,
  parameter int               CNT_W     = cpu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ready,
  input  logic             stall_i,
  input  logic             redir_vld,
  input  logic [XLEN-1:0]  redir_pc,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [XLEN-1:0]  epc_i,
  input  logic             halt_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_vld_o,
  output logic [XLEN-1:0]  pc_next_o,
  output logic             flush_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  bad_pc_o,
  output logic [CNT_W-1:0] fetch_cnt_o
);

  pc_state_t       state;
  logic            accept;
  logic [XLEN-1:0] mux_pc;
  logic            mux_flush;
  logic            mux_misalign;
  logic            mux_halt;
  logic            mux_count;

  assign accept    = pc_vld_o & if_ready & ~stall_i;
  assign pc_next_o = pc_o + XLEN'(STEP);

  pc_next_mux #(
    .XLEN    (XLEN),
    .EXC_VEC (EXC_VEC),
    .STEP    (STEP)
  ) u_mux (
    .pc           (pc_o),
    .exc_req      (exc_req),
    .eret_req     (eret_req),
    .epc_i        (epc_i),
    .redir_vld    (redir_vld),
    .redir_pc     (redir_pc),
    .halt_i       (halt_i),
    .accept       (accept),
    .next_pc      (mux_pc),
    .flush        (mux_flush),
    .set_misalign (mux_misalign),
    .go_halt      (mux_halt),
    .count        (mux_count)
  );

  // flush_o defaults low each cycle so it only marks the first cycle of a new PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BOOT;
      pc_o        <= RESET_VEC;
      pc_vld_o    <= 1'b0;
      flush_o     <= 1'b0;
      misalign_o  <= 1'b0;
      bad_pc_o    <= '0;
      fetch_cnt_o <= '0;
    end else begin
      flush_o <= 1'b0;
      case (state)
        BOOT: begin
          state    <= RUN;
          pc_vld_o <= 1'b1;
        end
        RUN: begin
          pc_o    <= mux_pc;
          flush_o <= mux_flush;
          if (mux_misalign) begin
            misalign_o <= 1'b1;
            bad_pc_o   <= redir_pc;
          end
          if (exc_req) begin
            misalign_o <= 1'b0;
          end
          if (mux_halt) begin
            state    <= HALT;
            pc_vld_o <= 1'b0;
          end
          if (mux_count) begin
            fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
          end
        end
        HALT: begin
          if (exc_req) begin
            state      <= RUN;
            pc_vld_o   <= 1'b1;
            pc_o       <= EXC_VEC;
            flush_o    <= 1'b1;
            misalign_o <= 1'b0;
          end
        end
        default: begin
          state    <= BOOT;
          pc_vld_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
